rmii_rx_framer: RTL and testbench

- Receive front end for the RMII PHY interface. It sits directly upstream of the dibit shift-register assembler and drives that stage's data_in and trigger.
- Registers CRS_DV/RXD, detects the preamble and SFD, and strips them.
- Resolves RMII end-of-frame CRS_DV toggling and emits one trigger pulse per payload dibit, plus byte and frame framing strobes for the MAC layer.

---
 rtl/rmii_rx_framer.sv | 187 ++++++++++++++++++
 tb/tb_rmii_rx_framer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rmii_rx_framer.sv
// RMII receive framer: strips preamble/SFD, absorbs end-of-frame CRS_DV toggling and
// emits one trigger per payload dibit plus byte/frame strobes for the MAC.
module rmii_rx_framer #(
    parameter int unsigned MIN_PREAMBLE_DIBITS = 4,
    parameter int unsigned MAX_FRAME_BYTES     = 1522,
    parameter int unsigned COUNT_WIDTH         = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   sample_en,
    input  logic                   crs_dv_in,
    input  logic [1:0]             rxd_in,
    output logic [1:0]             data_out,
    output logic                   trigger,
    output logic                   byte_valid,
    output logic                   frame_start,
    output logic                   frame_end,
    output logic                   frame_err,
    output logic [COUNT_WIDTH-1:0] byte_count
);

    localparam int unsigned PRE_W = $clog2(MIN_PREAMBLE_DIBITS + 1) + 1;
    localparam logic [PRE_W-1:0]       PRE_MIN  = PRE_W'(MIN_PREAMBLE_DIBITS);
    localparam logic [COUNT_WIDTH-1:0] BYTE_MAX = COUNT_WIDTH'(MAX_FRAME_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_DROP,
        S_DROP_ERR
    } state_t;

    state_t                 state_q, state_d;
    logic                   crs_r_q, crs_r_d;
    logic [1:0]             rxd_r_q, rxd_r_d;
    logic                   zero_q, zero_d;
    logic [PRE_W-1:0]       pre_cnt_q, pre_cnt_d;
    logic                   pend_valid_q, pend_valid_d;
    logic [1:0]             pend_q, pend_d;
    logic [1:0]             phase_q, phase_d;
    logic [COUNT_WIDTH-1:0] byte_count_q, byte_count_d;
    logic [1:0]             data_out_q, data_out_d;
    logic                   trigger_q, trigger_d;
    logic                   byte_valid_q, byte_valid_d;
    logic                   frame_start_q, frame_start_d;
    logic                   frame_end_q, frame_end_d;
    logic                   frame_err_q, frame_err_d;
    logic                   term_c;

    // Two consecutive carrier-low samples end a frame or a drop.
    assign term_c = zero_q & ~crs_r_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= S_IDLE;
            crs_r_q       <= 1'b0;
            rxd_r_q       <= 2'b00;
            zero_q        <= 1'b0;
            pre_cnt_q     <= '0;
            pend_valid_q  <= 1'b0;
            pend_q        <= 2'b00;
            phase_q       <= 2'b00;
            byte_count_q  <= '0;
            data_out_q    <= 2'b00;
            trigger_q     <= 1'b0;
            byte_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            crs_r_q       <= crs_r_d;
            rxd_r_q       <= rxd_r_d;
            zero_q        <= zero_d;
            pre_cnt_q     <= pre_cnt_d;
            pend_valid_q  <= pend_valid_d;
            pend_q        <= pend_d;
            phase_q       <= phase_d;
            byte_count_q  <= byte_count_d;
            data_out_q    <= data_out_d;
            trigger_q     <= trigger_d;
            byte_valid_q  <= byte_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            frame_err_q   <= frame_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        crs_r_d       = crs_r_q;
        rxd_r_d       = rxd_r_q;
        zero_d        = zero_q;
        pre_cnt_d     = pre_cnt_q;
        pend_valid_d  = pend_valid_q;
        pend_d        = pend_q;
        phase_d       = phase_q;
        byte_count_d  = byte_count_q;
        data_out_d    = data_out_q;
        trigger_d     = 1'b0;
        byte_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        frame_err_d   = 1'b0;

        if (sample_en) begin
            crs_r_d = crs_dv_in;
            rxd_r_d = rxd_in;
            zero_d  = ~crs_r_q;
            case (state_q)
                S_IDLE: begin
                    if (crs_r_q) begin
                        case (rxd_r_q)
                            2'b00: state_d = S_IDLE;
                            2'b01: begin
                                state_d   = S_PREAMBLE;
                                pre_cnt_d = PRE_W'(1);
                            end
                            default: state_d = S_DROP;
                        endcase
                    end
                end
                S_PREAMBLE: begin
                    if (!crs_r_q) begin
                        state_d = S_IDLE;
                    end else if (rxd_r_q == 2'b01) begin
                        if (pre_cnt_q != '1) pre_cnt_d = pre_cnt_q + PRE_W'(1);
                    end else if (rxd_r_q == 2'b11 && pre_cnt_q >= PRE_MIN) begin
                        state_d       = S_DATA;
                        frame_start_d = 1'b1;
                        byte_count_d  = '0;
                        phase_d       = 2'b00;
                        pend_valid_d  = 1'b0;
                    end else begin
                        state_d = S_DROP;
                    end
                end
                S_DATA: begin
                    if (term_c) begin
                        state_d      = S_IDLE;
                        frame_end_d  = 1'b1;
                        frame_err_d  = (phase_q != 2'b00);
                        pend_valid_d = 1'b0;
                    end else begin
                        // Pending dibit is confirmed by this sample; emit it or hit the size limit.
                        if (pend_valid_q) begin
                            if (byte_count_q == BYTE_MAX) begin
                                state_d = S_DROP_ERR;
                            end else begin
                                data_out_d = pend_q;
                                trigger_d  = 1'b1;
                                phase_d    = phase_q + 2'd1;
                                if (phase_q == 2'b11) begin
                                    byte_valid_d = 1'b1;
                                    byte_count_d = byte_count_q + COUNT_WIDTH'(1);
                                end
                            end
                        end
                        pend_valid_d = 1'b1;
                        pend_d       = rxd_r_q;
                    end
                end
                S_DROP: begin
                    if (term_c) state_d = S_IDLE;
                end
                S_DROP_ERR: begin
                    if (term_c) begin
                        state_d     = S_IDLE;
                        frame_end_d = 1'b1;
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign data_out    = data_out_q;
    assign trigger     = trigger_q;
    assign byte_valid  = byte_valid_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign frame_err   = frame_err_q;
    assign byte_count  = byte_count_q;

endmodule

// File: tb/tb_rmii_rx_framer.sv
// Bench for rmii_rx_framer: two instances (default and 2-byte limit) share the pins and are
// checked against a frame-level model of the expected dibits, strobes and timing.
module tb_rmii_rx_framer;

    localparam int MIN_PRE   = 4;
    localparam int MAX_BIG   = 1522;
    localparam int MAX_SMALL = 2;
    localparam int CW        = 16;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          sample_en;
    logic          crs_dv_in;
    logic [1:0]    rxd_in;
    logic [1:0]    dout  [2];
    logic          trig  [2];
    logic          bv    [2];
    logic          fs    [2];
    logic          fe    [2];
    logic          ferr  [2];
    logic [CW-1:0] bc    [2];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit slow     = 1'b0;
    int div      = 0;

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (slow) begin
            div       = (div == 9) ? 0 : div + 1;
            sample_en = (div == 9);
        end else begin
            sample_en = 1'b1;
        end
    end

    rmii_rx_framer #(.MIN_PREAMBLE_DIBITS(MIN_PRE), .MAX_FRAME_BYTES(MAX_BIG), .COUNT_WIDTH(CW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .sample_en(sample_en), .crs_dv_in(crs_dv_in), .rxd_in(rxd_in),
        .data_out(dout[0]), .trigger(trig[0]), .byte_valid(bv[0]), .frame_start(fs[0]),
        .frame_end(fe[0]), .frame_err(ferr[0]), .byte_count(bc[0]));

    rmii_rx_framer #(.MIN_PREAMBLE_DIBITS(MIN_PRE), .MAX_FRAME_BYTES(MAX_SMALL), .COUNT_WIDTH(CW)) dut_small (
        .clk_in(clk_in), .rst_in(rst_in), .sample_en(sample_en), .crs_dv_in(crs_dv_in), .rxd_in(rxd_in),
        .data_out(dout[1]), .trigger(trig[1]), .byte_valid(bv[1]), .frame_start(fs[1]),
        .frame_end(fe[1]), .frame_err(ferr[1]), .byte_count(bc[1]));

    // Observation record
    logic [1:0] od0[$], od1[$];
    int         oc0[$], oc1[$];
    int         n_start[2], n_end[2], n_bv[2], viol[2], end_cyc[2];
    logic       last_err[2];
    int         exp_bc[2];

    always @(negedge clk_in) begin
        for (int u = 0; u < 2; u++) begin
            if (trig[u]) begin
                if (u == 0) begin od0.push_back(dout[0]); oc0.push_back(cyc); end
                else        begin od1.push_back(dout[1]); oc1.push_back(cyc); end
            end
            if (fs[u]) n_start[u]++;
            if (bv[u]) n_bv[u]++;
            if (fe[u]) begin n_end[u]++; end_cyc[u] = cyc; last_err[u] = ferr[u]; end
            if ((trig[u] && fs[u]) || (bv[u] && !trig[u]) || (ferr[u] && !fe[u])) viol[u]++;
        end
    end

    // Payload samples after the SFD (carrier, dibit)
    bit         pc[$];
    logic [1:0] pd[$];

    task automatic clear_obs();
        od0.delete(); od1.delete(); oc0.delete(); oc1.delete();
        for (int u = 0; u < 2; u++) begin
            n_start[u] = 0; n_end[u] = 0; n_bv[u] = 0; viol[u] = 0; end_cyc[u] = -1; last_err[u] = 1'b0;
        end
    endtask

    task automatic send(input logic c, input logic [1:0] d);
        int k;
        crs_dv_in = c;
        rxd_in    = d;
        k = 0;
        do begin
            @(posedge clk_in);
            k++;
        end while (!sample_en && k < 20);
        @(negedge clk_in);
    endtask

    task automatic push(input bit c, input logic [1:0] d);
        pc.push_back(c);
        pd.push_back(d);
    endtask

    task automatic push_end();
        push(1'b0, 2'($urandom));
        push(1'b0, 2'($urandom));
    endtask

    task automatic run_frame(input string name, input int pre_len, input int lead);
        int dcyc[$];
        int term, len, en, maxb, ng, gc;
        bit acc, err;
        logic [1:0] gd;
        clear_obs();
        repeat (3) send(1'b0, 2'($urandom));
        repeat (lead) send(1'b1, 2'b00);
        repeat (pre_len) send(1'b1, 2'b01);
        send(1'b1, 2'b11);
        foreach (pc[j]) begin
            dcyc.push_back(cyc);
            send(pc[j], pd[j]);
        end
        repeat (4) send(1'b0, 2'($urandom));

        // Frame ends at the first carrier-low pair; the dibit before the final low is dropped.
        acc  = (pre_len >= MIN_PRE);
        term = pc.size() - 1;
        for (int j = pc.size() - 1; j >= 1; j--) if (!pc[j-1] && !pc[j]) term = j;
        len = term - 1;
        for (int u = 0; u < 2; u++) begin
            maxb = (u == 0) ? MAX_BIG : MAX_SMALL;
            en   = acc ? ((len > 4 * maxb) ? 4 * maxb : len) : 0;
            err  = (len > 4 * maxb) || (en % 4 != 0);
            if (acc) exp_bc[u] = en / 4;
            ng = (u == 0) ? od0.size() : od1.size();

            checks++;
            if (n_start[u] != (acc ? 1 : 0)) begin
                failures++; $display("FAIL %s u%0d frame_start count: got %0d expected %0d", name, u, n_start[u], acc ? 1 : 0);
            end
            checks++;
            if (n_end[u] != (acc ? 1 : 0)) begin
                failures++; $display("FAIL %s u%0d frame_end count: got %0d expected %0d", name, u, n_end[u], acc ? 1 : 0);
            end
            checks++;
            if (ng != en) begin
                failures++; $display("FAIL %s u%0d trigger count: got %0d expected %0d", name, u, ng, en);
            end
            for (int k = 0; k < en && k < ng; k++) begin
                gd = (u == 0) ? od0[k] : od1[k];
                gc = (u == 0) ? oc0[k] : oc1[k];
                checks++;
                if (gd !== pd[k]) begin
                    failures++; $display("FAIL %s u%0d data_out[%0d]: got %b expected %b", name, u, k, gd, pd[k]);
                end
                if (!slow) begin
                    checks++;
                    if (gc != dcyc[k] + 3) begin
                        failures++; $display("FAIL %s u%0d trigger cycle[%0d]: got %0d expected %0d", name, u, k, gc, dcyc[k] + 3);
                    end
                end
            end
            checks++;
            if (n_bv[u] != en / 4) begin
                failures++; $display("FAIL %s u%0d byte_valid count: got %0d expected %0d", name, u, n_bv[u], en / 4);
            end
            checks++;
            if (bc[u] !== CW'(exp_bc[u])) begin
                failures++; $display("FAIL %s u%0d byte_count: got %0d expected %0d", name, u, bc[u], exp_bc[u]);
            end
            if (acc) begin
                checks++;
                if (last_err[u] !== err) begin
                    failures++; $display("FAIL %s u%0d frame_err: got %b expected %b", name, u, last_err[u], err);
                end
                if (!slow) begin
                    checks++;
                    if (end_cyc[u] != dcyc[term] + 2) begin
                        failures++; $display("FAIL %s u%0d frame_end cycle: got %0d expected %0d", name, u, end_cyc[u], dcyc[term] + 2);
                    end
                end
            end
            checks++;
            if (viol[u] != 0) begin
                failures++; $display("FAIL %s u%0d strobe overlap: got %0d expected 0", name, u, viol[u]);
            end
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        crs_dv_in = 1'b1;
        rxd_in = 2'b01;
        repeat (3) @(negedge clk_in);
        for (int u = 0; u < 2; u++) begin
            checks++;
            if ({dout[u], trig[u], bv[u], fs[u], fe[u], ferr[u], bc[u]} !== '0) begin
                failures++;
                $display("FAIL reset u%0d outputs: got %h expected 0", u, {dout[u], trig[u], bv[u], fs[u], fe[u], ferr[u], bc[u]});
            end
            exp_bc[u] = 0;
        end
        crs_dv_in = 1'b0;
        rxd_in = 2'b00;
        rst_in = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic test_basic(input string name);
        pc.delete(); pd.delete();
        push(1'b1, 2'b10); push(1'b1, 2'b01); push(1'b1, 2'b10); push(1'b1, 2'b11);
        push_end();
        run_frame(name, 7, 1);
    endtask

    task automatic test_toggle_tail();
        pc.delete(); pd.delete();
        repeat (8) push(1'b1, 2'($urandom));
        push(1'b0, 2'($urandom)); push(1'b1, 2'($urandom));
        push(1'b0, 2'($urandom)); push(1'b1, 2'($urandom));
        push_end();
        run_frame("toggle_tail", 5, 0);
    endtask

    task automatic test_short_preamble();
        pc.delete(); pd.delete();
        repeat (4) push(1'b1, 2'($urandom));
        push_end();
        run_frame("short_pre", 2, 0);
        test_basic("after_short");
    endtask

    task automatic test_partial_byte();
        pc.delete(); pd.delete();
        repeat (6) push(1'b1, 2'($urandom));
        push_end();
        run_frame("partial", 4, 2);
    endtask

    task automatic test_oversize();
        pc.delete(); pd.delete();
        repeat (12) push(1'b1, 2'($urandom));
        push_end();
        run_frame("oversize", 6, 0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            pc.delete(); pd.delete();
            repeat ($urandom_range(0, 24)) push(1'b1, 2'($urandom));
            repeat ($urandom_range(0, 3)) begin
                push(1'b0, 2'($urandom));
                push(1'b1, 2'($urandom));
            end
            push_end();
            run_frame("random", $urandom_range(1, 9), $urandom_range(0, 2));
        end
    endtask

    task automatic test_slow_and_reset();
        slow = 1'b1;
        test_basic("slow_basic");
        clear_obs();
        repeat (3) send(1'b0, 2'b00);
        repeat (6) send(1'b1, 2'b01);
        send(1'b1, 2'b11);
        send(1'b1, 2'b10);
        send(1'b1, 2'b01);
        send(1'b1, 2'b11);
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);
        for (int u = 0; u < 2; u++) begin
            checks++;
            if ({dout[u], trig[u], bv[u], fs[u], fe[u], ferr[u], bc[u]} !== '0) begin
                failures++;
                $display("FAIL mid_reset u%0d outputs: got %h expected 0", u, {dout[u], trig[u], bv[u], fs[u], fe[u], ferr[u], bc[u]});
            end
            checks++;
            if (n_end[u] != 0) begin
                failures++; $display("FAIL mid_reset u%0d frame_end count: got %0d expected 0", u, n_end[u]);
            end
            exp_bc[u] = 0;
        end
        rst_in = 1'b0;
        @(negedge clk_in);
        test_basic("slow_after_reset");
        slow = 1'b0;
        repeat (12) @(negedge clk_in);
    endtask

    initial begin
        rst_in    = 1'b1;
        sample_en = 1'b1;
        crs_dv_in = 1'b0;
        rxd_in    = 2'b00;
        clear_obs();
        @(negedge clk_in);
        test_reset();
        test_basic("basic");
        test_toggle_tail();
        test_short_preamble();
        test_partial_byte();
        test_oversize();
        test_random();
        test_slow_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
